// File: rtl/fir_cfg_loader.sv
// fir_cfg_loader: responder side of the FIR band/filter-select change detector.
// When enable is seen in IDLE, the requested config is staged, TAPS coefficients
// are fetched from the coefficient generator and written into the coefficient RAM.
// The staged config is then committed to the shadow outputs. The shadow outputs
// feed back to the detector and close the loop.
//
// Coefficient handshake: coef_req is held high for the whole LOAD phase with
// coef_idx naming the requested tap. A cycle with coef_req and coef_ack both high
// transfers coef_data for that coef_idx, and coef_idx advances on the next cycle.
// coef_ack while coef_req is low carries no meaning and is ignored.
module fir_cfg_loader #(
    parameter int TAPS    = 32,
    parameter int CW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             bandlow,
    input  logic [15:0]             bandhi,
    input  logic [1:0]              filter_select,
    output logic [15:0]             bandlowo,
    output logic [15:0]             bandhio,
    output logic [1:0]              filter_selecto,
    output logic [15:0]             cfg_bandlow,
    output logic [15:0]             cfg_bandhi,
    output logic [1:0]              cfg_fsel,
    output logic                    coef_req,
    output logic [$clog2(TAPS)-1:0] coef_idx,
    input  logic                    coef_ack,
    input  logic [CW-1:0]           coef_data,
    output logic                    coef_we,
    output logic [$clog2(TAPS)-1:0] coef_waddr,
    output logic [CW-1:0]           coef_wdata,
    output logic                    filt_hold,
    output logic                    done,
    output logic                    cfg_err,
    output logic [1:0]              dbg_state
);

    localparam int IW = $clog2(TAPS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            tmo_hit;
    logic            idx_last;

    logic [15:0]     shadow_bandlow_q;
    logic [15:0]     shadow_bandhi_q;
    logic [1:0]      shadow_fsel_q;
    logic [15:0]     staged_bandlow_q;
    logic [15:0]     staged_bandhi_q;
    logic [1:0]      staged_fsel_q;

    logic            coef_req_q;
    logic            coef_we_q;
    logic [IW-1:0]   coef_waddr_q;
    logic [CW-1:0]   coef_wdata_q;
    logic            filt_hold_q;
    logic            done_q;
    logic            cfg_err_q;

    // Ack-wait timer step and end-of-load / timeout conditions.
    always_comb begin
        timer_d  = timer_q + 1'b1;
        tmo_hit  = (timer_q == TW'(TIMEOUT - 1));
        idx_last = (idx_q == IW'(TAPS - 1));
    end

    // Loader FSM: every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            timer_q          <= '0;
            shadow_bandlow_q <= '0;
            shadow_bandhi_q  <= '0;
            shadow_fsel_q    <= '0;
            staged_bandlow_q <= '0;
            staged_bandhi_q  <= '0;
            staged_fsel_q    <= '0;
            coef_req_q       <= 1'b0;
            coef_we_q        <= 1'b0;
            coef_waddr_q     <= '0;
            coef_wdata_q     <= '0;
            filt_hold_q      <= 1'b0;
            done_q           <= 1'b0;
            cfg_err_q        <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            coef_we_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        // Inputs are captured only here; later changes wait for the next load.
                        staged_bandlow_q <= bandlow;
                        staged_bandhi_q  <= bandhi;
                        staged_fsel_q    <= filter_select;
                        idx_q            <= '0;
                        timer_q          <= '0;
                        coef_req_q       <= 1'b1;
                        filt_hold_q      <= 1'b1;
                        state_q          <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (coef_ack) begin
                        coef_we_q    <= 1'b1;
                        coef_waddr_q <= idx_q;
                        coef_wdata_q <= coef_data;
                        timer_q      <= '0;
                        if (idx_last) begin
                            // Last tap: commit so the shadow is visible together with done.
                            shadow_bandlow_q <= staged_bandlow_q;
                            shadow_bandhi_q  <= staged_bandhi_q;
                            shadow_fsel_q    <= staged_fsel_q;
                            done_q           <= 1'b1;
                            coef_req_q       <= 1'b0;
                            state_q          <= S_COMMIT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Abort leaves the shadow alone, so the detector keeps enable high and we retry.
                        cfg_err_q   <= 1'b1;
                        coef_req_q  <= 1'b0;
                        filt_hold_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                S_COMMIT: begin
                    filt_hold_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    coef_req_q  <= 1'b0;
                    filt_hold_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bandlowo       = shadow_bandlow_q;
    assign bandhio        = shadow_bandhi_q;
    assign filter_selecto = shadow_fsel_q;
    assign cfg_bandlow    = staged_bandlow_q;
    assign cfg_bandhi     = staged_bandhi_q;
    assign cfg_fsel       = staged_fsel_q;
    assign coef_req       = coef_req_q;
    assign coef_idx       = idx_q;
    assign coef_we        = coef_we_q;
    assign coef_waddr     = coef_waddr_q;
    assign coef_wdata     = coef_wdata_q;
    assign filt_hold      = filt_hold_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fir_cfg_loader.sv
// tb_fir_cfg_loader: scoreboard bench for fir_cfg_loader. Stimulus pushes the expected
// output events (RAM writes, commits, aborts) into exp_q; a monitor pops on every
// coef_we / done / cfg_err and compares. The detector and coefficient generator are
// modelled in the bench.
module tb_fir_cfg_loader;

    localparam int TAPS    = 32;
    localparam int CW      = 16;
    localparam int TIMEOUT = 255;
    localparam int IW      = $clog2(TAPS);
    localparam int EW      = 36;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [15:0]   bandlow;
    logic [15:0]   bandhi;
    logic [1:0]    filter_select;
    logic [15:0]   bandlowo;
    logic [15:0]   bandhio;
    logic [1:0]    filter_selecto;
    logic [15:0]   cfg_bandlow;
    logic [15:0]   cfg_bandhi;
    logic [1:0]    cfg_fsel;
    logic          coef_req;
    logic [IW-1:0] coef_idx;
    logic          coef_ack;
    logic [CW-1:0] coef_data;
    logic          coef_we;
    logic [IW-1:0] coef_waddr;
    logic [CW-1:0] coef_wdata;
    logic          filt_hold;
    logic          done;
    logic          cfg_err;
    logic [1:0]    dbg_state;

    logic [67:0]   cfg_outs;
    logic [30:0]   ctl_outs;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    logic [33:0]   model_shadow;
    logic [CW-1:0] gen_mem [TAPS];
    bit            gen_random;
    bit            hold_en;
    int            hold_idx;
    int            miss_run;

    fir_cfg_loader #(.TAPS(TAPS), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .bandlow        (bandlow),
        .bandhi         (bandhi),
        .filter_select  (filter_select),
        .bandlowo       (bandlowo),
        .bandhio        (bandhio),
        .filter_selecto (filter_selecto),
        .cfg_bandlow    (cfg_bandlow),
        .cfg_bandhi     (cfg_bandhi),
        .cfg_fsel       (cfg_fsel),
        .coef_req       (coef_req),
        .coef_idx       (coef_idx),
        .coef_ack       (coef_ack),
        .coef_data      (coef_data),
        .coef_we        (coef_we),
        .coef_waddr     (coef_waddr),
        .coef_wdata     (coef_wdata),
        .filt_hold      (filt_hold),
        .done           (done),
        .cfg_err        (cfg_err),
        .dbg_state      (dbg_state)
    );

    // Clock and run-time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    // Change detector: enable whenever the requested config differs from the committed one.
    assign enable   = (bandlow != bandlowo) || (bandhi != bandhio) || (filter_select != filter_selecto);
    assign cfg_outs = {bandlowo, bandhio, filter_selecto, cfg_bandlow, cfg_bandhi, cfg_fsel};
    assign ctl_outs = {coef_req, coef_idx, coef_we, coef_waddr, coef_wdata, filt_hold, done, cfg_err};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Expected event stream for a load: writes 0..n-1 in order.
    task automatic push_writes(input int n);
        logic [EW-1:0] e;
        for (int i = 0; i < n; i++) begin
            e = {K_WR, 13'd0, IW'(i), gen_mem[i]};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_load(input logic [33:0] cfg);
        push_writes(TAPS);
        exp_q.push_back({K_DONE, cfg});
        model_shadow = cfg;
    endtask

    task automatic push_err();
        exp_q.push_back({K_ERR, model_shadow});
    endtask

    task automatic set_cfg(input logic [33:0] cfg);
        @(negedge clk);
        {bandlow, bandhi, filter_select} = cfg;
    endtask

    task automatic fill_gen(input bit ramp);
        for (int i = 0; i < TAPS; i++) gen_mem[i] = ramp ? CW'(i) : CW'($urandom);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idx(input int idx, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(coef_req && coef_idx == IW'(idx)) && n < budget);
        chk("reach_idx", {coef_req, coef_idx}, {1'b1, IW'(idx)});
    endtask

    // Coefficient generator: acks requests and checks the length of a withheld-ack run.
    always @(negedge clk) begin
        bit ack;
        if (cfg_err) begin
            chk("timeout_len", miss_run, TIMEOUT);
            miss_run = 0;
        end
        if (coef_req) begin
            if (hold_en && coef_idx == IW'(hold_idx)) ack = 1'b0;
            else if (gen_random) ack = (miss_run >= 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
            else ack = 1'b1;
            coef_ack  = ack;
            coef_data = ack ? gen_mem[coef_idx] : CW'($urandom);
            miss_run  = ack ? 0 : miss_run + 1;
        end else begin
            coef_ack  = gen_random ? 1'($urandom_range(0, 1)) : 1'b0;
            coef_data = CW'($urandom);
        end
    end

    // Monitor: pop one expected event per DUT output event.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (coef_we) begin
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            chk("write_kind", e[35:34], K_WR);
            chk("write_addr", coef_waddr, e[16 +: IW]);
            chk("write_data", coef_wdata, e[15:0]);
        end
        if (done) begin
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            chk("done_kind", e[35:34], K_DONE);
            chk("done_shadow", {bandlowo, bandhio, filter_selecto}, e[33:0]);
        end
        if (cfg_err) begin
            e = '0;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            chk("err_kind", e[35:34], K_ERR);
            chk("err_shadow", {bandlowo, bandhio, filter_selecto}, e[33:0]);
        end
    end

    // Directed scenarios followed by randomized reloads.
    initial begin
        int cyc;
        int n;
        logic [33:0] cfg;
        n_checks      = 0;
        n_errors      = 0;
        model_shadow  = '0;
        gen_random    = 1'b0;
        hold_en       = 1'b0;
        hold_idx      = 0;
        miss_run      = 0;
        coef_ack      = 1'b0;
        coef_data     = '0;
        reset         = 1'b1;
        bandlow       = '0;
        bandhi        = '0;
        filter_select = '0;
        fill_gen(1'b1);

        // Reset values, then 20 quiet cycles with zero inputs.
        repeat (3) @(negedge clk);
        chk("reset_cfg_outs", cfg_outs, 0);
        chk("reset_ctl_outs", ctl_outs, 0);
        chk("reset_state", dbg_state, 0);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("quiet_outputs", {cfg_outs, ctl_outs}, 0);
        end

        // Full load with ack tied high and data equal to the tap index.
        cfg = {16'h0100, 16'h0800, 2'd2};
        push_load(cfg);
        set_cfg(cfg);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("load_start", {coef_req, coef_idx, filt_hold}, {1'b1, IW'(0), 1'b1});
                chk("staged_cfg", {cfg_bandlow, cfg_bandhi, cfg_fsel}, cfg);
            end
        end while (done !== 1'b1 && cyc < 100);
        chk("done_latency", cyc, TAPS + 1);
        @(negedge clk);
        chk("hold_released", {filt_hold, coef_req}, 2'b00);
        wait_drain("ramp_load", 50);

        // Ack withheld at tap 5: abort, shadow kept, restart from tap 0.
        fill_gen(1'b0);
        hold_idx = 5;
        hold_en  = 1'b1;
        cfg = {16'h0200, 16'h0a00, 2'd1};
        push_writes(5);
        push_err();
        push_load(cfg);
        set_cfg(cfg);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cfg_err !== 1'b1 && n < TIMEOUT + 100);
        chk("err_seen", cfg_err, 1'b1);
        hold_en = 1'b0;
        @(negedge clk);
        chk("retry_idx", {coef_req, coef_idx}, {1'b1, IW'(0)});
        wait_drain("timeout_retry", 200);

        // Input change mid-load: old config commits first, then a second load.
        fill_gen(1'b0);
        cfg = {16'h0100, 16'h0800, 2'd2};
        push_load(cfg);
        push_load({16'h0100, 16'h0900, 2'd2});
        set_cfg(cfg);
        wait_idx(10, 100);
        bandhi = 16'h0900;
        @(negedge clk);
        chk("staged_kept", cfg_bandhi, 16'h0800);
        wait_drain("mid_change", 300);
        chk("final_shadow", {bandlowo, bandhio, filter_selecto}, {16'h0100, 16'h0900, 2'd2});

        // Reset at tap 17, then a complete reload.
        fill_gen(1'b0);
        cfg = {16'h1234, 16'h5678, 2'd3};
        push_writes(17);
        set_cfg(cfg);
        wait_idx(17, 100);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_cfg", cfg_outs, 0);
        chk("async_reset_ctl", ctl_outs, 0);
        chk("partial_writes", exp_q.size(), 0);
        model_shadow = '0;
        push_load(cfg);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_drain("after_reset", 200);

        // Random configs, random ack gaps and ack noise outside LOAD.
        gen_random = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fill_gen(1'b0);
            do begin
                cfg = {16'($urandom), 16'($urandom), 2'($urandom_range(0, 3))};
            end while (cfg == model_shadow);
            push_load(cfg);
            set_cfg(cfg);
            wait_drain("random_load", 1500);
        end
        gen_random = 1'b0;

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
